// File: rtl/system_onchip_memory_arbiter_if.sv
// rtl/system_onchip_memory_arbiter_if.sv - Avalon-MM style requester bus between a master and the arbiter
`timescale 1ns/1ps
interface system_onchip_memory_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/system_onchip_memory_arbiter.sv
// rtl/system_onchip_memory_arbiter.sv - round-robin sharing of one single-port RAM between two requesters
// with an optional post-reset clear sweep.
`timescale 1ns/1ps
module system_onchip_memory_arbiter #(
  parameter int              ADDR_W         = 12,
  parameter int              DATA_W         = 32,
  parameter int              BE_W           = 4,
  parameter int              DEPTH          = 4096,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  system_onchip_memory_arbiter_if.slave a,
  system_onchip_memory_arbiter_if.slave b,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [BE_W-1:0]        mem_byteenable,
  output logic                   mem_chipselect,
  output logic                   mem_write,
  output logic [DATA_W-1:0]      mem_writedata,
  output logic                   mem_clken,
  input  logic [DATA_W-1:0]      mem_readdata,
  output logic                   init_busy
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
  logic              last_grant_b, last_grant_nx;
  logic              a_rvalid, b_rvalid;
  logic              a_rvalid_nx, b_rvalid_nx;
  logic              req_a, req_b;
  logic              grant_a, grant_b;
  logic              cs_int, wr_int;

  assign req_a = a.read | a.write;
  assign req_b = b.read | b.write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RESET_STATE;
      clr_cnt      <= '0;
      last_grant_b <= 1'b1;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
    end else begin
      state        <= state_nx;
      clr_cnt      <= clr_cnt_nx;
      last_grant_b <= last_grant_nx;
      a_rvalid     <= a_rvalid_nx;
      b_rvalid     <= b_rvalid_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    clr_cnt_nx     = clr_cnt;
    last_grant_nx  = last_grant_b;
    grant_a        = 1'b0;
    grant_b        = 1'b0;
    cs_int         = 1'b0;
    wr_int         = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    init_busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        init_busy      = 1'b1;
        cs_int         = 1'b1;
        wr_int         = 1'b1;
        mem_byteenable = '1;
        mem_address    = clr_cnt;
        mem_writedata  = CLEAR_VALUE;
        clr_cnt_nx     = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) state_nx = ST_RUN;
      end
      ST_RUN: begin
        // On contention the port that did not win last time gets the slot.
        grant_a = req_a & (~req_b | last_grant_b);
        grant_b = req_b & (~req_a | ~last_grant_b);
        if (grant_a) begin
          cs_int         = 1'b1;
          wr_int         = a.write;
          mem_address    = a.address;
          mem_byteenable = a.byteenable;
          mem_writedata  = a.writedata;
          last_grant_nx  = 1'b0;
        end else if (grant_b) begin
          cs_int         = 1'b1;
          wr_int         = b.write;
          mem_address    = b.address;
          mem_byteenable = b.byteenable;
          mem_writedata  = b.writedata;
          last_grant_nx  = 1'b1;
        end
      end
      default: state_nx = RESET_STATE;
    endcase
  end

  // A read+write request is a write; it produces no read response.
  assign a_rvalid_nx = grant_a & a.read & ~a.write;
  assign b_rvalid_nx = grant_b & b.read & ~b.write;

  assign mem_chipselect = reset_n & cs_int;
  assign mem_write      = reset_n & wr_int;
  assign mem_clken      = 1'b1;

  assign a.waitrequest   = ~reset_n | (state == ST_CLEAR) | (req_a & ~grant_a);
  assign b.waitrequest   = ~reset_n | (state == ST_CLEAR) | (req_b & ~grant_b);
  assign a.readdatavalid = a_rvalid;
  assign b.readdatavalid = b_rvalid;
  assign a.readdata      = mem_readdata;
  assign b.readdata      = mem_readdata;

endmodule

// File: tb/tb_system_onchip_memory_arbiter.sv
// tb/tb_system_onchip_memory_arbiter.sv - directed self-checking bench for system_onchip_memory_arbiter
`timescale 1ns/1ps
module tb_system_onchip_memory_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  system_onchip_memory_arbiter_if #(.ADDR_W(12), .DATA_W(32), .BE_W(4)) a_bus();
  system_onchip_memory_arbiter_if #(.ADDR_W(12), .DATA_W(32), .BE_W(4)) b_bus();
  system_onchip_memory_arbiter_if #(.ADDR_W(12), .DATA_W(32), .BE_W(4)) a2_bus();
  system_onchip_memory_arbiter_if #(.ADDR_W(12), .DATA_W(32), .BE_W(4)) b2_bus();

  logic [11:0] mem_address, mem2_address;
  logic [3:0]  mem_byteenable, mem2_byteenable;
  logic        mem_chipselect, mem2_chipselect;
  logic        mem_write, mem2_write;
  logic [31:0] mem_writedata, mem2_writedata;
  logic        mem_clken, mem2_clken;
  logic [31:0] mem_readdata;
  logic [31:0] mem2_readdata;
  logic        init_busy, init_busy2;

  assign mem2_readdata = 32'h1234_5678;

  system_onchip_memory_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .a(a_bus), .b(b_bus),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .init_busy(init_busy)
  );

  system_onchip_memory_arbiter #(.CLEAR_ON_RESET(1'b0)) dut2 (
    .clk(clk), .reset_n(rst2_n), .a(a2_bus), .b(b2_bus),
    .mem_address(mem2_address), .mem_byteenable(mem2_byteenable),
    .mem_chipselect(mem2_chipselect), .mem_write(mem2_write),
    .mem_writedata(mem2_writedata), .mem_clken(mem2_clken),
    .mem_readdata(mem2_readdata), .init_busy(init_busy2)
  );

  // Single-port RAM with one-cycle read latency, pre-filled with a marker so the clear sweep is visible.
  logic [31:0] ram [0:4095];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 32'hAAAA_AAAA;
      ram_ready <= 1'b1;
    end else if (mem_chipselect) begin
      if (mem_write) begin
        for (int j = 0; j < 4; j++)
          if (mem_byteenable[j]) ram[mem_address][8*j +: 8] <= mem_writedata[8*j +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit pb, input bit rd, input bit wr, input logic [11:0] addr,
                       input logic [31:0] d, input logic [3:0] be);
    a_bus.read = 1'b0; a_bus.write = 1'b0;
    b_bus.read = 1'b0; b_bus.write = 1'b0;
    if (!pb) begin
      a_bus.read = rd; a_bus.write = wr; a_bus.address = addr;
      a_bus.writedata = d; a_bus.byteenable = be;
    end else begin
      b_bus.read = rd; b_bus.write = wr; b_bus.address = addr;
      b_bus.writedata = d; b_bus.byteenable = be;
    end
  endtask

  task automatic bus_write(input string tag, input bit pb, input logic [11:0] addr,
                           input logic [31:0] d, input logic [3:0] be);
    step();
    drive(pb, 1'b0, 1'b1, addr, d, be);
    @(negedge clk);
    check_eq({tag, "_wait"}, pb ? b_bus.waitrequest : a_bus.waitrequest, 32'd0);
  endtask

  task automatic bus_read(input string tag, input bit pb, input logic [11:0] addr,
                          input logic [31:0] exp);
    step();
    drive(pb, 1'b1, 1'b0, addr, 32'd0, 4'hF);
    @(negedge clk);
    check_eq({tag, "_wait"}, pb ? b_bus.waitrequest : a_bus.waitrequest, 32'd0);
    step();
    drive(pb, 1'b0, 1'b0, 12'd0, 32'd0, 4'h0);
    @(negedge clk);
    check_eq({tag, "_valid"}, pb ? b_bus.readdatavalid : a_bus.readdatavalid, 32'd1);
    check_eq({tag, "_data"}, pb ? b_bus.readdata : a_bus.readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    bit wait_ok;
    int ia, ib, pend_a, pend_b, cnt_a, cnt_b;

    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 4'h0);
    a2_bus.read = 1'b0; a2_bus.write = 1'b0; a2_bus.address = '0;
    a2_bus.writedata = '0; a2_bus.byteenable = '0;
    b2_bus.read = 1'b0; b2_bus.write = 1'b0; b2_bus.address = '0;
    b2_bus.writedata = '0; b2_bus.byteenable = '0;
    repeat (3) step();

    @(negedge clk);
    check_eq("rst_wait_a", a_bus.waitrequest, 32'd1);
    check_eq("rst_wait_b", b_bus.waitrequest, 32'd1);
    check_eq("rst_valid_a", a_bus.readdatavalid, 32'd0);
    check_eq("rst_cs", mem_chipselect, 32'd0);
    check_eq("rst_write", mem_write, 32'd0);
    check_eq("rst_busy", init_busy, 32'd1);
    check_eq("rst_clken", mem_clken, 32'd1);

    // No clear sweep: first cycle after release is already serviceable.
    step();
    rst2_n = 1'b1;
    a2_bus.read = 1'b1; a2_bus.address = 12'd5;
    @(negedge clk);
    check_eq("nc_busy", init_busy2, 32'd0);
    check_eq("nc_wait", a2_bus.waitrequest, 32'd0);
    check_eq("nc_cs", mem2_chipselect, 32'd1);
    check_eq("nc_addr", mem2_address, 32'd5);
    step();
    a2_bus.read = 1'b0;
    @(negedge clk);
    check_eq("nc_valid", a2_bus.readdatavalid, 32'd1);
    check_eq("nc_data", a2_bus.readdata, 32'h1234_5678);

    // Clear sweep length and blocked ports.
    step();
    reset_n = 1'b1;
    a_bus.read = 1'b1; a_bus.address = 12'd7;
    busy_cycles = 0;
    wait_ok = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!init_busy) break;
      busy_cycles++;
      if (!a_bus.waitrequest || !b_bus.waitrequest || a_bus.readdatavalid) wait_ok = 1'b0;
    end
    check_eq("clr_cycles", busy_cycles, 32'd4096);
    check_eq("clr_blocked", {31'd0, wait_ok}, 32'd1);
    bus_read("clr_rd0", 1'b0, 12'd0, 32'h0);
    bus_read("clr_rd4095", 1'b1, 12'd4095, 32'h0);

    // Byte-enabled write then immediate read.
    bus_write("be_wr", 1'b0, 12'h010, 32'hDEAD_BEEF, 4'b0011);
    bus_read("be_rd", 1'b0, 12'h010, 32'h0000_BEEF);

    // Preload distinct data; the final B write leaves last_grant=B.
    for (int i = 0; i < 4; i++) bus_write("pre_a", 1'b0, 12'h100 + 12'(i), 32'hA000_0000 + i, 4'hF);
    for (int i = 0; i < 4; i++) bus_write("pre_b", 1'b1, 12'h200 + 12'(i), 32'hB000_0000 + i, 4'hF);

    // Continuous contention: A on even cycles, B on odd.
    ia = 0; ib = 0; pend_a = -1; pend_b = -1; cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 4'h0);
      if (k < 8) begin
        a_bus.read = 1'b1; a_bus.address = 12'h100 + 12'(ia);
        b_bus.read = 1'b1; b_bus.address = 12'h200 + 12'(ib);
      end
      @(negedge clk);
      cnt_a += int'(a_bus.readdatavalid);
      cnt_b += int'(b_bus.readdatavalid);
      check_eq("rr_valid_a", a_bus.readdatavalid, (pend_a >= 0) ? 32'd1 : 32'd0);
      check_eq("rr_valid_b", b_bus.readdatavalid, (pend_b >= 0) ? 32'd1 : 32'd0);
      if (pend_a >= 0) check_eq("rr_data_a", a_bus.readdata, 32'hA000_0000 + pend_a);
      if (pend_b >= 0) check_eq("rr_data_b", b_bus.readdata, 32'hB000_0000 + pend_b);
      pend_a = -1; pend_b = -1;
      if (k < 8) begin
        check_eq("rr_wait_a", a_bus.waitrequest, {31'd0, k[0]});
        check_eq("rr_wait_b", b_bus.waitrequest, {31'd0, ~k[0]});
        if (!k[0]) begin pend_a = ia; ia++; end
        else       begin pend_b = ib; ib++; end
      end
    end
    check_eq("rr_cnt_a", cnt_a, 32'd4);
    check_eq("rr_cnt_b", cnt_b, 32'd4);

    // A write vs B read on the same word with last_grant=B.
    step();
    drive(1'b0, 1'b0, 1'b1, 12'h020, 32'h1, 4'hF);
    b_bus.read = 1'b1; b_bus.address = 12'h020;
    @(negedge clk);
    check_eq("cf_wait_a", a_bus.waitrequest, 32'd0);
    check_eq("cf_wait_b", b_bus.waitrequest, 32'd1);
    step();
    a_bus.write = 1'b0;
    @(negedge clk);
    check_eq("cf_wait_b2", b_bus.waitrequest, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 4'h0);
    @(negedge clk);
    check_eq("cf_valid_b", b_bus.readdatavalid, 32'd1);
    check_eq("cf_data_b", b_bus.readdata, 32'h1);

    // Reset between a granted read and its response drops the response and restarts the sweep.
    step();
    drive(1'b0, 1'b1, 1'b0, 12'h010, 32'd0, 4'h0);
    @(negedge clk);
    check_eq("mr_wait_a", a_bus.waitrequest, 32'd0);
    reset_n = 1'b0;
    step();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 4'h0);
    @(negedge clk);
    check_eq("mr_valid_a", a_bus.readdatavalid, 32'd0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("mr_valid_a2", a_bus.readdatavalid, 32'd0);
    check_eq("mr_busy", init_busy, 32'd1);
    check_eq("mr_addr0", mem_address, 32'd0);
    check_eq("mr_write", mem_write, 32'd1);
    step();
    @(negedge clk);
    check_eq("mr_addr1", mem_address, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
